// File: rtl/expr_tokenizer_if.sv
// rtl/expr_tokenizer_if.sv - byte-in / token-out handshake bundle for expr_tokenizer
// Signals: in_valid/in_ready/in_data carry ASCII bytes into the lexer;
//          tok_valid/tok_ready/tok_type/tok_value/tok_last carry tokens out.
// Modports: master = byte source and token sink, slave = the lexer.
interface expr_tokenizer_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             tok_valid;
  logic             tok_ready;
  logic [2:0]       tok_type;
  logic [WIDTH-1:0] tok_value;
  logic             tok_last;

  modport master (
    output in_valid, in_data, tok_ready,
    input  in_ready, tok_valid, tok_type, tok_value, tok_last
  );

  modport slave (
    input  in_valid, in_data, tok_ready,
    output in_ready, tok_valid, tok_type, tok_value, tok_last
  );
endinterface

// File: rtl/expr_tokenizer.sv
// rtl/expr_tokenizer.sv - ASCII expression lexer emitting NUM/operator/paren/END/ERR tokens
// Ports: clk; rst (synchronous, active-high);
//        bus (slave): in_valid/in_ready/in_data byte stream in,
//        tok_valid/tok_ready/tok_type/tok_value/tok_last token stream out.
// Token types: 0 NUM, 1 ADD, 2 SUB, 3 MUL, 4 LPAREN, 5 RPAREN, 6 END, 7 ERR.
module expr_tokenizer #(
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             rst,
  expr_tokenizer_if.slave bus
);
  localparam logic [2:0] TOK_NUM = 3'd0;
  localparam logic [2:0] TOK_ADD = 3'd1;
  localparam logic [2:0] TOK_SUB = 3'd2;
  localparam logic [2:0] TOK_MUL = 3'd3;
  localparam logic [2:0] TOK_LP  = 3'd4;
  localparam logic [2:0] TOK_RP  = 3'd5;
  localparam logic [2:0] TOK_END = 3'd6;
  localparam logic [2:0] TOK_ERR = 3'd7;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_NUM,
    ST_SIGN,
    ST_DRAIN
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             neg_q, neg_d;
  logic             expect_q, expect_d;
  logic             pend_valid_q, pend_valid_d;
  logic [7:0]       pend_byte_q, pend_byte_d;

  logic             tok_valid_q;
  logic [2:0]       tok_type_q;
  logic [WIDTH-1:0] tok_value_q;
  logic             tok_last_q;

  logic             emit;
  logic [2:0]       emit_type;
  logic [WIDTH-1:0] emit_value;

  logic             out_free;
  logic             in_ready_w;
  logic             accept;
  logic             use_pend;
  logic             step;
  logic [7:0]       byte_cur;
  logic             is_digit;
  logic [WIDTH-1:0] digit_val;
  logic [WIDTH-1:0] acc_x10;

  assign out_free   = !tok_valid_q || bus.tok_ready;
  // DRAIN never emits, so it can swallow bytes regardless of the output register.
  assign in_ready_w = !rst && ((state_q == ST_DRAIN) || (!pend_valid_q && out_free));
  assign accept     = bus.in_valid && in_ready_w;
  // The delimiter parked behind a NUM token is replayed as a SCAN byte;
  // in_ready is low while it is pending, so it never collides with a new byte.
  assign use_pend   = !rst && pend_valid_q && out_free;
  assign step       = accept || use_pend;
  assign byte_cur   = use_pend ? pend_byte_q : bus.in_data;
  assign is_digit   = (byte_cur >= 8'h30) && (byte_cur <= 8'h39);
  assign digit_val  = WIDTH'(byte_cur - 8'h30);
  assign acc_x10    = (acc_q << 3) + (acc_q << 1);

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    neg_d        = neg_q;
    expect_d     = expect_q;
    pend_valid_d = pend_valid_q;
    pend_byte_d  = pend_byte_q;
    emit         = 1'b0;
    emit_type    = TOK_NUM;
    emit_value   = '0;

    if (use_pend) begin
      pend_valid_d = 1'b0;
    end

    if (step) begin
      unique case (state_q)
        ST_SCAN: begin
          if (is_digit) begin
            acc_d   = digit_val;
            state_d = ST_NUM;
          end else begin
            unique case (byte_cur)
              8'h20: ;
              8'h2B: begin emit = 1'b1; emit_type = TOK_ADD; end
              8'h2A: begin emit = 1'b1; emit_type = TOK_MUL; end
              8'h28: begin emit = 1'b1; emit_type = TOK_LP;  end
              8'h29: begin emit = 1'b1; emit_type = TOK_RP;  end
              8'h00: begin emit = 1'b1; emit_type = TOK_END; end
              8'h2D: begin
                if (expect_q) begin
                  neg_d   = 1'b1;
                  state_d = ST_SIGN;
                end else begin
                  emit      = 1'b1;
                  emit_type = TOK_SUB;
                end
              end
              default: begin
                emit      = 1'b1;
                emit_type = TOK_ERR;
                acc_d     = '0;
                neg_d     = 1'b0;
                state_d   = ST_DRAIN;
              end
            endcase
          end
        end

        ST_NUM: begin
          if (is_digit) begin
            acc_d = acc_x10 + digit_val;
          end else begin
            emit         = 1'b1;
            emit_type    = TOK_NUM;
            emit_value   = neg_q ? (~acc_q + WIDTH'(1)) : acc_q;
            pend_valid_d = 1'b1;
            pend_byte_d  = byte_cur;
            neg_d        = 1'b0;
            state_d      = ST_SCAN;
          end
        end

        ST_SIGN: begin
          if (is_digit) begin
            acc_d   = digit_val;
            state_d = ST_NUM;
          end else begin
            emit      = 1'b1;
            emit_type = TOK_ERR;
            acc_d     = '0;
            neg_d     = 1'b0;
            // A terminator after the minus already ends the expression.
            state_d   = (byte_cur == 8'h00) ? ST_SCAN : ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          if (byte_cur == 8'h00) begin
            state_d = ST_SCAN;
          end
        end

        default: state_d = ST_SCAN;
      endcase
    end

    if (emit) begin
      expect_d = !((emit_type == TOK_NUM) || (emit_type == TOK_RP));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_SCAN;
      acc_q        <= '0;
      neg_q        <= 1'b0;
      expect_q     <= 1'b1;
      pend_valid_q <= 1'b0;
      pend_byte_q  <= '0;
      tok_valid_q  <= 1'b0;
      tok_type_q   <= TOK_NUM;
      tok_value_q  <= '0;
      tok_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      neg_q        <= neg_d;
      expect_q     <= expect_d;
      pend_valid_q <= pend_valid_d;
      pend_byte_q  <= pend_byte_d;
      // emit only happens when out_free, so loading here never overwrites a held token.
      if (emit) begin
        tok_valid_q <= 1'b1;
        tok_type_q  <= emit_type;
        tok_value_q <= emit_value;
        tok_last_q  <= (emit_type == TOK_END) || (emit_type == TOK_ERR);
      end else if (bus.tok_ready) begin
        tok_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.tok_valid = tok_valid_q;
  assign bus.tok_type  = tok_type_q;
  assign bus.tok_value = tok_value_q;
  assign bus.tok_last  = tok_last_q;
endmodule

// File: tb/tb_expr_tokenizer.sv
// tb/tb_expr_tokenizer.sv - self-checking bench for expr_tokenizer
module tb_expr_tokenizer;
  localparam logic [2:0] T_NUM = 3'd0, T_ADD = 3'd1, T_SUB = 3'd2, T_MUL = 3'd3;
  localparam logic [2:0] T_LP = 3'd4, T_RP = 3'd5, T_END = 3'd6, T_ERR = 3'd7;

  typedef logic [7:0] bq_t[$];

  typedef struct packed {
    logic [2:0]  t;
    logic [31:0] v;
    logic        last;
  } tok_t;

  typedef struct packed {
    logic [15:0][7:0] text;
    logic [1:0]       rmode;
    logic [3:0]       n;
    logic [7:0][2:0]  t;
    logic [7:0][31:0] v;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   rmode = 0;
  tok_t got_q[$];
  tok_t exp_q[$];
  vec_t vecs[$];
  vec_t cur;

  expr_tokenizer_if #(.WIDTH(32)) bus ();
  expr_tokenizer #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  // tok_ready policy: 0 always ready, 1 toggle, 2 random, 3 held low
  initial begin
    bus.tok_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: bus.tok_ready = 1'b1;
        1: bus.tok_ready = ~bus.tok_ready;
        2: bus.tok_ready = 1'($urandom_range(0, 1));
        default: bus.tok_ready = 1'b0;
      endcase
    end
  end

  // Monitor: collects consumed tokens, checks hold stability and stall backpressure.
  initial begin
    logic hold_prev;
    tok_t held;
    hold_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst && hold_prev) begin
        checks++;
        if (!bus.tok_valid || bus.tok_type !== held.t || bus.tok_value !== held.v || bus.tok_last !== held.last) begin
          errors++;
          $display("FAIL hold_stable: got v=%0b t=%0d val=%h last=%0b, held t=%0d val=%h last=%0b",
                   bus.tok_valid, bus.tok_type, bus.tok_value, bus.tok_last, held.t, held.v, held.last);
        end
      end
      if (!rst && bus.tok_valid && !bus.tok_ready && bus.tok_type != T_ERR) begin
        checks++;
        if (bus.in_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_in_ready: got %0b expected 0", bus.in_ready);
        end
      end
      if (!rst && bus.tok_valid && bus.tok_ready)
        got_q.push_back('{t: bus.tok_type, v: bus.tok_value, last: bus.tok_last});
      hold_prev = !rst && bus.tok_valid && !bus.tok_ready;
      held = '{t: bus.tok_type, v: bus.tok_value, last: bus.tok_last};
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic void push_exp(input logic [2:0] t, input logic [31:0] v);
    exp_q.push_back('{t: t, v: v, last: (t == T_END) || (t == T_ERR)});
  endfunction

  function automatic bit is_dig(input logic [7:0] c);
    return c >= 8'h30 && c <= 8'h39;
  endfunction

  function automatic int after_zero(input bq_t s, input int from);
    int k = from + 1;
    while (k < s.size() && s[k] != 8'h00) k++;
    return k + 1;
  endfunction

  // Reference lexer: walks the whole byte string, reading complete literals at once.
  function automatic void model(input bq_t s);
    int i = 0;
    bit expect_op = 1'b1;
    while (i < s.size()) begin
      logic [7:0] c = s[i];
      if (c == 8'h20) begin
        i++;
      end else if (is_dig(c) || (c == 8'h2D && expect_op)) begin
        bit neg = (c == 8'h2D);
        longint unsigned val = 0;
        bit bad = 1'b0;
        if (neg) begin
          i++;
          if (!is_dig(s[i])) begin
            push_exp(T_ERR, 0);
            expect_op = 1'b1;
            bad = 1'b1;
            i = (s[i] == 8'h00) ? i + 1 : after_zero(s, i);
          end
        end
        if (!bad) begin
          logic [31:0] v32;
          while (is_dig(s[i])) begin
            val = (val * 10 + longint'(s[i] - 8'h30)) & 64'hFFFF_FFFF;
            i++;
          end
          v32 = val[31:0];
          push_exp(T_NUM, neg ? 32'(0 - val) : v32);
          expect_op = 1'b0;
        end
      end else begin
        i++;
        case (c)
          8'h2B: begin push_exp(T_ADD, 0); expect_op = 1'b1; end
          8'h2D: begin push_exp(T_SUB, 0); expect_op = 1'b1; end
          8'h2A: begin push_exp(T_MUL, 0); expect_op = 1'b1; end
          8'h28: begin push_exp(T_LP, 0);  expect_op = 1'b1; end
          8'h29: begin push_exp(T_RP, 0);  expect_op = 1'b0; end
          8'h00: begin push_exp(T_END, 0); expect_op = 1'b1; end
          default: begin
            push_exp(T_ERR, 0);
            expect_op = 1'b1;
            i = after_zero(s, i - 1);
          end
        endcase
      end
    end
  endfunction

  function automatic bq_t text_bytes(input logic [15:0][7:0] t, input bit term);
    bq_t q;
    for (int k = 15; k >= 0; k--) if (t[k] != 8'h00) q.push_back(t[k]);
    if (term) q.push_back(8'h00);
    return q;
  endfunction

  // Called aligned to posedge+1; returns aligned to posedge+1.
  task automatic send(input bq_t b, input bit gaps);
    for (int k = 0; k < b.size(); k++) begin
      bit fire;
      int guard;
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = b[k];
      guard = 0;
      fire  = 1'b0;
      while (!fire && guard < 200) begin
        @(negedge clk);
        fire = bus.in_ready;
        @(posedge clk);
        #1;
        guard++;
      end
      checks++;
      if (!fire) begin
        errors++;
        $display("FAIL send_accept: byte %0d (%h) not accepted within 200 cycles", k, b[k]);
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic compare_tokens(input string name);
    int guard = 0;
    while (got_q.size() < exp_q.size() && guard < 2000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    repeat (4) begin @(posedge clk); #1; end
    chk({name, "_count"}, got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL %s[%0d]: got t=%0d v=%h last=%0b expected t=%0d v=%h last=%0b", name, k,
                 got_q[k].t, got_q[k].v, got_q[k].last, exp_q[k].t, exp_q[k].v, exp_q[k].last);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tok_valid", bus.tok_valid, 0);
    @(posedge clk);
    #1;
    got_q.delete();
  endtask

  function automatic void vbegin(input logic [15:0][7:0] s, input logic [1:0] rm);
    cur = '0;
    cur.text = s;
    cur.rmode = rm;
  endfunction

  function automatic void vtok(input logic [2:0] t, input logic [31:0] v);
    cur.t[cur.n] = t;
    cur.v[cur.n] = v;
    cur.n = cur.n + 1;
  endfunction

  function automatic void vend();
    vecs.push_back(cur);
  endfunction

  initial begin
    bq_t rs;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    vbegin("2 * 4", 0);  vtok(T_NUM, 2); vtok(T_MUL, 0); vtok(T_NUM, 4); vtok(T_END, 0); vend();
    vbegin("-5 * (12 + 3)", 0);
    vtok(T_NUM, 32'hFFFF_FFFB); vtok(T_MUL, 0); vtok(T_LP, 0); vtok(T_NUM, 12);
    vtok(T_ADD, 0); vtok(T_NUM, 3); vtok(T_RP, 0); vtok(T_END, 0); vend();
    vbegin("10 - -20", 1); vtok(T_NUM, 10); vtok(T_SUB, 0); vtok(T_NUM, 32'hFFFF_FFEC); vtok(T_END, 0); vend();
    vbegin("2 # 3", 0);  vtok(T_NUM, 2); vtok(T_ERR, 0); vend();
    vbegin("7", 0);      vtok(T_NUM, 7); vtok(T_END, 0); vend();
    vbegin("4294967297", 0); vtok(T_NUM, 1); vtok(T_END, 0); vend();
    vbegin("- 3", 0);    vtok(T_ERR, 0); vend();
    vbegin("8*(9)", 1);
    vtok(T_NUM, 8); vtok(T_MUL, 0); vtok(T_LP, 0); vtok(T_NUM, 9); vtok(T_RP, 0); vtok(T_END, 0); vend();
    vbegin("3-2", 0);    vtok(T_NUM, 3); vtok(T_SUB, 0); vtok(T_NUM, 2); vtok(T_END, 0); vend();
    vbegin("-", 0);      vtok(T_ERR, 0); vend();
    vbegin("5", 0);      vtok(T_NUM, 5); vtok(T_END, 0); vend();
    vbegin("  ", 0);     vtok(T_END, 0); vend();
    vbegin("(-1)", 1);   vtok(T_LP, 0); vtok(T_NUM, 32'hFFFF_FFFF); vtok(T_RP, 0); vtok(T_END, 0); vend();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tok_valid", bus.tok_valid, 0);
    chk("reset_tok_type", bus.tok_type, 0);
    chk("reset_tok_value", bus.tok_value, 0);
    chk("reset_tok_last", bus.tok_last, 0);
    chk("reset_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Table-driven expressions
    for (int k = 0; k < vecs.size(); k++) begin
      rmode = int'(vecs[k].rmode);
      for (int j = 0; j < int'(vecs[k].n); j++) push_exp(vecs[k].t[j], vecs[k].v[j]);
      send(text_bytes(vecs[k].text, 1'b1), 1'b0);
      compare_tokens($sformatf("vec%0d", k));
    end

    // Delimiter after a literal: NUM first, in_ready low while the delimiter waits
    rmode = 0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h35;
    @(negedge clk);
    chk("pend_idle_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_data = 8'h2B;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("pend_num_valid", bus.tok_valid, 1);
    chk("pend_num_type", bus.tok_type, T_NUM);
    chk("pend_num_value", bus.tok_value, 5);
    chk("pend_in_ready", bus.in_ready, 0);
    @(negedge clk);
    chk("pend_add_type", bus.tok_type, T_ADD);
    chk("pend_add_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    push_exp(T_NUM, 5); push_exp(T_ADD, 0); push_exp(T_NUM, 1); push_exp(T_END, 0);
    send(text_bytes("1", 1'b1), 1'b0);
    compare_tokens("pend_seq");

    // Held token and pending END are both discarded by reset
    rmode = 3;
    @(posedge clk);
    #1;
    send(text_bytes("7", 1'b1), 1'b0);
    repeat (2) @(negedge clk);
    chk("held_valid", bus.tok_valid, 1);
    chk("held_value", bus.tok_value, 7);
    chk("held_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    pulse_reset();
    rmode = 0;
    push_exp(T_NUM, 9); push_exp(T_END, 0);
    send(text_bytes("9", 1'b1), 1'b0);
    compare_tokens("after_held_reset");

    // Partial literal discarded by reset
    send(text_bytes("12", 1'b0), 1'b0);
    pulse_reset();
    push_exp(T_NUM, 3); push_exp(T_END, 0);
    send(text_bytes("3", 1'b1), 1'b0);
    compare_tokens("after_partial_reset");

    // Randomized stream against the reference lexer
    rmode = 2;
    for (int e = 0; e < 40; e++) begin
      int len = $urandom_range(0, 10);
      for (int k = 0; k < len; k++) begin
        int r = $urandom_range(0, 99);
        if (r < 40)      rs.push_back(8'h30 + 8'($urandom_range(0, 9)));
        else if (r < 50) rs.push_back(8'h20);
        else if (r < 60) rs.push_back(8'h2D);
        else if (r < 67) rs.push_back(8'h2B);
        else if (r < 74) rs.push_back(8'h2A);
        else if (r < 82) rs.push_back(8'h28);
        else if (r < 90) rs.push_back(8'h29);
        else if (r < 95) rs.push_back(8'h23);
        else for (int d = 0; d < 11; d++) rs.push_back(8'h30 + 8'($urandom_range(0, 9)));
      end
      rs.push_back(8'h00);
    end
    model(rs);
    send(rs, 1'b1);
    compare_tokens("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
